// File: rtl/regfile_port_arbiter.sv
// Two-port round-robin arbiter in front of the 32x8 register file.
// Each accepted request takes one register-file cycle and returns a one-cycle response pulse.
module regfile_port_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FLAG_W   = 7,
  parameter int unsigned FLAG_REG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0 request / response
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_a1,
  input  logic [ADDR_W-1:0] req0_a2,
  input  logic [ADDR_W-1:0] req0_a3,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [FLAG_W-1:0] req0_flags,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rd1,
  output logic [DATA_W-1:0] rsp0_rd2,
  output logic              rsp0_err,
  // port 1 request / response
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_a1,
  input  logic [ADDR_W-1:0] req1_a2,
  input  logic [ADDR_W-1:0] req1_a3,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [FLAG_W-1:0] req1_flags,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rd1,
  output logic [DATA_W-1:0] rsp1_rd2,
  output logic              rsp1_err,
  // register file side
  output logic [7:0]        rf_a1,
  output logic [7:0]        rf_a2,
  output logic [7:0]        rf_a3,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [FLAG_W-1:0] rf_flags,
  output logic              rf_we,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e              state_q;
  logic                ptr_q;
  logic                port_q;
  logic                write_q;
  logic [ADDR_W-1:0]   a1_q, a2_q, a3_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [FLAG_W-1:0]   flags_q;

  logic                idle;
  logic                sel_port;
  logic                accept;
  logic                is_flag_reg;

  // Pointer only breaks ties; a lone requester wins regardless of it.
  assign idle        = (state_q == StIdle);
  assign sel_port    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign req0_ready  = idle && req0_valid && !sel_port;
  assign req1_ready  = idle && req1_valid && sel_port;
  assign accept      = req0_ready || req1_ready;
  assign is_flag_reg = (a3_q == ADDR_W'(FLAG_REG));

  always_comb begin
    rf_a1    = '0;
    rf_a2    = '0;
    rf_a3    = '0;
    rf_wdata = '0;
    rf_flags = '0;
    rf_we    = 1'b0;
    rf_re    = 1'b0;
    if (state_q == StRead) begin
      rf_re = 1'b1;
      rf_a1 = 8'(a1_q);
      rf_a2 = 8'(a2_q);
    end
    // Writes to the flag register are dropped so data and flags never collide there.
    if (state_q == StWrite && !is_flag_reg) begin
      rf_we    = 1'b1;
      rf_a3    = 8'(a3_q);
      rf_wdata = wdata_q;
      rf_flags = flags_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      port_q     <= 1'b0;
      write_q    <= 1'b0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      wdata_q    <= '0;
      flags_q    <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rd1   <= '0;
      rsp0_rd2   <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rd1   <= '0;
      rsp1_rd2   <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            port_q  <= sel_port;
            ptr_q   <= !sel_port;
            write_q <= sel_port ? req1_write : req0_write;
            a1_q    <= sel_port ? req1_a1    : req0_a1;
            a2_q    <= sel_port ? req1_a2    : req0_a2;
            a3_q    <= sel_port ? req1_a3    : req0_a3;
            wdata_q <= sel_port ? req1_wdata : req0_wdata;
            flags_q <= sel_port ? req1_flags : req0_flags;
            state_q <= (sel_port ? req1_write : req0_write) ? StWrite : StRead;
          end
        end
        StRead: begin
          if (port_q) begin
            rsp1_valid <= 1'b1;
            rsp1_rd1   <= rf_rd1;
            rsp1_rd2   <= rf_rd2;
            rsp1_err   <= 1'b0;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rd1   <= rf_rd1;
            rsp0_rd2   <= rf_rd2;
            rsp0_err   <= 1'b0;
          end
          state_q <= StIdle;
        end
        StWrite: begin
          if (port_q) begin
            rsp1_valid <= 1'b1;
            rsp1_rd1   <= '0;
            rsp1_rd2   <= '0;
            rsp1_err   <= is_flag_reg;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rd1   <= '0;
            rsp0_rd2   <= '0;
            rsp0_err   <= is_flag_reg;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: register-file model, vector table, response scoreboard
// and hand-written sequences for arbitration and mid-write reset.
module tb_regfile_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req0_ready, req0_write;
  logic [4:0] req0_a1, req0_a2, req0_a3;
  logic [7:0] req0_wdata;
  logic [6:0] req0_flags;
  logic       rsp0_valid, rsp0_err;
  logic [7:0] rsp0_rd1, rsp0_rd2;
  logic       req1_valid, req1_ready, req1_write;
  logic [4:0] req1_a1, req1_a2, req1_a3;
  logic [7:0] req1_wdata;
  logic [6:0] req1_flags;
  logic       rsp1_valid, rsp1_err;
  logic [7:0] rsp1_rd1, rsp1_rd2;
  logic [7:0] rf_a1, rf_a2, rf_a3, rf_wdata, rf_rd1, rf_rd2;
  logic [6:0] rf_flags;
  logic       rf_we, rf_re;

  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_a1(req0_a1), .req0_a2(req0_a2), .req0_a3(req0_a3),
    .req0_wdata(req0_wdata), .req0_flags(req0_flags),
    .rsp0_valid(rsp0_valid), .rsp0_rd1(rsp0_rd1), .rsp0_rd2(rsp0_rd2), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_a1(req1_a1), .req1_a2(req1_a2), .req1_a3(req1_a3),
    .req1_wdata(req1_wdata), .req1_flags(req1_flags),
    .rsp1_valid(rsp1_valid), .rsp1_rd1(rsp1_rd1), .rsp1_rd2(rsp1_rd2), .rsp1_err(rsp1_err),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wdata(rf_wdata), .rf_flags(rf_flags),
    .rf_we(rf_we), .rf_re(rf_re), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  // Register file model: unwritten registers read a fixed pattern; every write also stores flags
  // into register 3.
  logic [7:0] mem [32];
  bit   [31:0] wr_mask;

  function automatic logic [7:0] init_val(input logic [4:0] a);
    return ({3'b000, a} * 8'd3) + 8'd16;
  endfunction

  assign rf_rd1 = wr_mask[rf_a1[4:0]] ? mem[rf_a1[4:0]] : init_val(rf_a1[4:0]);
  assign rf_rd2 = wr_mask[rf_a2[4:0]] ? mem[rf_a2[4:0]] : init_val(rf_a2[4:0]);

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_a3[4:0]]     <= rf_wdata;
      wr_mask[rf_a3[4:0]] <= 1'b1;
      mem[3]              <= {1'b0, rf_flags};
      wr_mask[3]          <= 1'b1;
    end
  end

  typedef struct packed {
    logic       port;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       err;
  } rsp_t;

  typedef struct packed {
    logic       port;
    logic       write;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic [7:0] wdata;
    logic [6:0] flags;
    logic [7:0] exp_rd1;
    logic [7:0] exp_rd2;
    logic       exp_err;
  } vec_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
      check("rf_addr_upper", 32'({rf_a1[7:5], rf_a2[7:5], rf_a3[7:5]}), 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp0_valid=%0b rsp1_valid=%0b, expected none at %0t",
                   rsp0_valid, rsp1_valid, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_both", 32'(rsp0_valid & rsp1_valid), 32'd0);
          check("rsp_port", 32'(rsp1_valid), 32'(mon_e.port));
          check("rsp_rd1", 32'(rsp1_valid ? rsp1_rd1 : rsp0_rd1), 32'(mon_e.rd1));
          check("rsp_rd2", 32'(rsp1_valid ? rsp1_rd2 : rsp0_rd2), 32'(mon_e.rd2));
          check("rsp_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic set_req(input logic p, input logic vld, input logic wr, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3, input logic [7:0] wd,
                         input logic [6:0] fl);
    if (p) begin
      req1_valid = vld; req1_write = wr; req1_a1 = a1; req1_a2 = a2; req1_a3 = a3;
      req1_wdata = wd; req1_flags = fl;
    end else begin
      req0_valid = vld; req0_write = wr; req0_a1 = a1; req0_a2 = a2; req0_a3 = a3;
      req0_wdata = wd; req0_flags = fl;
    end
  endtask

  function automatic vec_t mk(input logic p, input logic wr, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3, input logic [7:0] wd,
                              input logic [6:0] fl, input logic [7:0] r1, input logic [7:0] r2,
                              input logic er);
    vec_t v;
    v = '{port: p, write: wr, a1: a1, a2: a2, a3: a3, wdata: wd, flags: fl,
          exp_rd1: r1, exp_rd2: r2, exp_err: er};
    return v;
  endfunction

  // Single-port transaction with cycle-accurate checks of the register-file side.
  task automatic do_req(input vec_t v);
    int  n;
    logic rdy;
    logic do_wr;
    n = 0;
    do_wr = v.write && (v.a3 != 5'd3);
    @(negedge clk);
    set_req(v.port, 1'b1, v.write, v.a1, v.a2, v.a3, v.wdata, v.flags);
    #1;
    rdy = v.port ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
      rdy = v.port ? req1_ready : req0_ready;
    end
    check("grant_wait_cycles", 32'(n), 32'd0);
    if (!rdy) begin
      set_req(v.port, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
      return;
    end
    exp_q.push_back('{port: v.port, rd1: v.exp_rd1, rd2: v.exp_rd2, err: v.exp_err});
    @(posedge clk);
    #1;
    set_req(v.port, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    @(negedge clk);
    check("rf_re_access", 32'(rf_re), 32'(!v.write));
    check("rf_we_access", 32'(rf_we), 32'(do_wr));
    check("rsp_early", 32'(v.port ? rsp1_valid : rsp0_valid), 32'd0);
    if (do_wr) begin
      check("rf_a3", 32'(rf_a3), 32'({3'b000, v.a3}));
      check("rf_wdata", 32'(rf_wdata), 32'(v.wdata));
      check("rf_flags", 32'(rf_flags), 32'(v.flags));
    end else if (!v.write) begin
      check("rf_a1", 32'(rf_a1), 32'({3'b000, v.a1}));
      check("rf_a2", 32'(rf_a2), 32'({3'b000, v.a2}));
    end
    @(negedge clk);
    check("rsp_valid_c2", 32'(v.port ? rsp1_valid : rsp0_valid), 32'd1);
    check("rf_idle_c2", 32'({rf_we, rf_re}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic exp_port;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);

    vecs[0] = mk(1'b0, 1'b1, 5'd0,  5'd0, 5'd5,  8'hA7, 7'h15, 8'h00, 8'h00, 1'b0);
    vecs[1] = mk(1'b1, 1'b0, 5'd5,  5'd3, 5'd0,  8'h00, 7'h00, 8'hA7, 8'h15, 1'b0);
    vecs[2] = mk(1'b0, 1'b1, 5'd0,  5'd0, 5'd3,  8'h55, 7'h2A, 8'h00, 8'h00, 1'b1);
    vecs[3] = mk(1'b0, 1'b0, 5'd3,  5'd5, 5'd0,  8'h00, 7'h00, 8'h15, 8'hA7, 1'b0);
    vecs[4] = mk(1'b1, 1'b1, 5'd0,  5'd0, 5'd31, 8'hFF, 7'h7F, 8'h00, 8'h00, 1'b0);
    vecs[5] = mk(1'b1, 1'b0, 5'd31, 5'd3, 5'd0,  8'h00, 7'h00, 8'hFF, 8'h7F, 1'b0);
    vecs[6] = mk(1'b0, 1'b0, 5'd0,  5'd1, 5'd0,  8'h00, 7'h00, 8'h10, 8'h13, 1'b0);
    vecs[7] = mk(1'b1, 1'b1, 5'd0,  5'd0, 5'd0,  8'h00, 7'h00, 8'h00, 8'h00, 1'b0);
    vecs[8] = mk(1'b0, 1'b0, 5'd0,  5'd3, 5'd0,  8'h00, 7'h00, 8'h00, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    check("reset_rsp0", 32'({rsp0_valid, rsp0_rd1, rsp0_rd2, rsp0_err}), 32'd0);
    check("reset_rsp1", 32'({rsp1_valid, rsp1_rd1, rsp1_rd2, rsp1_err}), 32'd0);
    check("reset_rf", 32'({rf_we, rf_re, rf_a1, rf_a3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'({req0_ready, req1_ready}), 32'd0);

    for (int i = 0; i < 9; i++) do_req(vecs[i]);

    // Pointer now favours port 1, then port 0; a lone port 1 must still win immediately.
    do_req(mk(1'b1, 1'b0, 5'd31, 5'd5, 5'd0, 8'h00, 7'h00, 8'hFF, 8'hA7, 1'b0));
    do_req(mk(1'b1, 1'b0, 5'd31, 5'd5, 5'd0, 8'h00, 7'h00, 8'hFF, 8'hA7, 1'b0));

    // Both ports hold valid reads; grants must alternate starting with port 0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 8'd0, 7'd0);
    set_req(1'b1, 1'b1, 1'b0, 5'd3, 5'd1,  5'd0, 8'd0, 7'd0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 6) begin
        @(negedge clk);
        #1;
        n++;
      end
      exp_port = (k % 2) != 0;
      check("alt_gap", 32'(n), (k == 0) ? 32'd0 : 32'd1);
      check("alt_grant", 32'({req1_ready, req0_ready}), exp_port ? 32'd2 : 32'd1);
      if (req0_ready)
        exp_q.push_back('{port: 1'b0, rd1: 8'hA7, rd2: 8'hFF, err: 1'b0});
      else if (req1_ready)
        exp_q.push_back('{port: 1'b1, rd1: 8'h00, rd2: 8'h13, err: 1'b0});
      if (k < 3) @(negedge clk);
    end
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    repeat (3) @(negedge clk);

    // Reset during a write to register 7: no write, no response, pointer back to port 0.
    set_req(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 8'h5A, 7'h11);
    #1;
    check("rst_seq_ready", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    check("rst_seq_we_before", 32'(rf_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_seq_we_after", 32'({rf_we, rf_re, rf_a3}), 32'd0);
    check("rst_seq_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 5'd7, 5'd3, 5'd0, 8'd0, 7'd0);
    set_req(1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 5'd0, 8'd0, 7'd0);
    #1;
    check("rst_seq_ptr", 32'({req1_ready, req0_ready}), 32'd1);
    if (req0_ready) exp_q.push_back('{port: 1'b0, rd1: 8'h25, rd2: 8'h00, err: 1'b0});
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'd0, 7'd0);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
